// File: rtl/multiplier_pipelined_param.sv
// Pipelined WIDTH x WIDTH array multiplier, ROWS_PER_STAGE partial-product rows per stage, LATENCY = STAGES+1.
// Back-pressure: out_valid & ~out_ready freezes the whole pipe; optional signed mode under `MULT_SIGNED_EN.
module multiplier_pipelined_param #(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 2,
    localparam int STAGES        = WIDTH / ROWS_PER_STAGE,
    localparam int LATENCY       = STAGES + 1,
    localparam int CNT_W         = $clog2(LATENCY + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef MULT_SIGNED_EN
    input  logic                 signed_mode,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic [CNT_W-1:0]     inflight
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [STAGES-1:0] sm_q;
    logic [STAGES:0]   v_q;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              stall, accept, deliver, sm_in;

`ifdef MULT_SIGNED_EN
    assign sm_in = signed_mode;
`else
    assign sm_in = 1'b0;
`endif

    assign stall     = v_q[STAGES] & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign deliver   = v_q[STAGES] & out_ready;
    assign out_valid = v_q[STAGES];
    assign inflight  = inflight_q;

    // Stage k adds rows [(k-1)*RPS, k*RPS) to the running sum from stage k-1.
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        logic [PW-1:0] acc_in;
        logic [PW-1:0] acc_d;
        logic [PW-1:0] acc_q;

        if (k == 1) begin : g_first
            assign acc_in = '0;
        end else begin : g_rest
            assign acc_in = g_stage[k-1].acc_q;
        end

        always_comb begin
            logic [PW-1:0] bx;
            logic [PW-1:0] sum;
            logic [PW-1:0] term;
            int            r;
            bx  = sm_q[k-1] ? {{WIDTH{b_q[k-1][WIDTH-1]}}, b_q[k-1]}
                            : {{WIDTH{1'b0}}, b_q[k-1]};
            sum = acc_in;
            for (int j = 0; j < ROWS_PER_STAGE; j++) begin
                r    = (k - 1) * ROWS_PER_STAGE + j;
                term = a_q[k-1][r] ? (bx << r) : '0;
                // Two's-complement: the MSB row of a carries negative weight.
                if (sm_q[k-1] && (r == WIDTH - 1)) begin
                    sum = sum - term;
                end else begin
                    sum = sum + term;
                end
            end
            acc_d = sum;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q <= '0;
            end else if (!stall) begin
                acc_q <= acc_d;
            end
        end
    end

    assign y = g_stage[STAGES].acc_q;

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !deliver) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (deliver && !accept) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q        <= '0;
            sm_q       <= '0;
            inflight_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            if (!stall) begin
                v_q     <= {v_q[STAGES-1:0], accept};
                a_q[0]  <= a;
                b_q[0]  <= b;
                sm_q[0] <= sm_in;
                for (int i = 1; i < STAGES; i++) begin
                    a_q[i]  <= a_q[i-1];
                    b_q[i]  <= b_q[i-1];
                    sm_q[i] <= sm_q[i-1];
                end
            end
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_multiplier_pipelined_param.sv
// Directed bench for multiplier_pipelined_param (WIDTH=8, ROWS_PER_STAGE=2, LATENCY=5).
module tb_multiplier_pipelined_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic [2:0]  inflight;
`ifdef MULT_SIGNED_EN
    logic        signed_mode = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    multiplier_pipelined_param #(.WIDTH(8), .ROWS_PER_STAGE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef MULT_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int got;
        int sent;
        int rcv;
        logic [15:0] exp_q [$];

        // Power-up reset
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_y", y, 16'h0);
        chk("rst_inflight", inflight, 3'd0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Single op 255*255, latency 5
        in_valid = 1'b1; a = 8'd255; b = 8'd255;
        #1; tick();
        in_valid = 1'b0; a = 8'd0; b = 8'd0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk("single_inflight", inflight, 3'd1);
            chk("single_out_valid", out_valid, (c == 5));
            if (c == 5) chk("single_y", y, 16'hFE01);
            tick();
        end
        #1;
        chk("single_inflight_after", inflight, 3'd0);
        chk("single_out_valid_after", out_valid, 1'b0);

        // Streaming a=i, b=i+1 back to back
        got = 0;
        for (int c = 0; c < 26; c++) begin
            in_valid = (c < 20);
            a = 8'(c);
            b = 8'(c + 1);
            #1;
            chk("stream_in_ready", in_ready, 1'b1);
            chk("stream_out_valid", out_valid, (c >= 5 && c < 25));
            if (out_valid) begin
                chk("stream_y", y, 16'((c - 5) * (c - 4)));
                got++;
            end
            tick();
        end
        chk("stream_count", got, 20);
        in_valid = 1'b0;

        // Back-pressure: 8 ops, out_ready low for cycles 7..12
        sent = 0; rcv = 0;
        for (int c = 0; c < 24; c++) begin
            in_valid  = (sent < 8);
            a         = 8'(sent + 10);
            b         = 8'(sent + 20);
            out_ready = !(c >= 7 && c <= 12);
            #1;
            chk("bp_in_ready", in_ready, !(c >= 7 && c <= 12));
            if (c >= 7 && c <= 12) begin
                chk("bp_inflight_sat", inflight, 3'd5);
                chk("bp_y_hold", y, 16'(12 * 22));
                chk("bp_out_valid_hold", out_valid, 1'b1);
            end
            if (out_valid && out_ready) begin
                chk("bp_y", y, 16'((rcv + 10) * (rcv + 20)));
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        chk("bp_rcv_count", rcv, 8);
        chk("bp_inflight_end", inflight, 3'd0);
        in_valid = 1'b0; out_ready = 1'b1;

        // Sparse: valid pattern 1,0,0,1
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 0 || c == 3);
            a = (c == 0) ? 8'd3 : 8'd0;
            b = (c == 0) ? 8'd7 : 8'd200;
            #1;
            chk("sparse_out_valid", out_valid, (c == 5 || c == 8));
            if (c == 5) chk("sparse_y0", y, 16'd21);
            if (c == 8) chk("sparse_y1", y, 16'd0);
            tick();
        end
        in_valid = 1'b0;

        // Reset mid-stream discards in-flight products
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; a = 8'(c + 5); b = 8'd9;
            #1; tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_y", y, 16'h0);
        chk("midrst_inflight", inflight, 3'd0);
        chk("midrst_in_ready", in_ready, 1'b1);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("midrst_no_output", out_valid, 1'b0);
        end

`ifdef MULT_SIGNED_EN
        exp_q = '{16'h4000, 16'hFFFF, 16'h00FF};
        for (int c = 0; c < 9; c++) begin
            in_valid    = (c < 3);
            signed_mode = (c < 2);
            a = (c == 0) ? 8'h80 : 8'hFF;
            b = (c == 0) ? 8'h80 : 8'h01;
            #1;
            chk("signed_out_valid", out_valid, (c >= 5 && c < 8));
            if (c >= 5 && c < 8) chk("signed_y", y, exp_q[c-5]);
            tick();
        end
        in_valid = 1'b0;
`else
        exp_q = {};
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
